mod_recombine: RTL

- Pipelined recombiner: computes dividend = quotient * m0 + remainder.
- Inverse of the team's Barrett quotient/remainder split. Used on the SNTRUP decode path to rebuild a value from its digit-and-carry representation.
- Valid/ready on both sides; one transaction per cycle when not stalled.
- Also flags non-canonical inputs, i.e. remainder >= m0 or m0 == 0.

---
 rtl/modcode_pkg.sv | 14 +
 rtl/mod_recombine_if.sv | 31 +++
 rtl/mod_recombine.sv | 94 +++++++++
 3 files changed

// File: rtl/modcode_pkg.sv
// Shared constants for the modular-code datapath blocks.
package modcode_pkg;

  // Default digit width (quotient, remainder and modulus).
  localparam int unsigned M0LEN_DEF = 14;

  // Accept-to-result latency of mod_recombine with no backpressure.
  localparam int unsigned MOD_RECOMBINE_LAT = 3;

  // SNTRUP moduli exercised on the decode path.
  localparam int unsigned SNTRUP_Q     = 4591;
  localparam int unsigned SNTRUP_Q_ENC = 1531;

endpackage

// File: rtl/mod_recombine_if.sv
// Valid/ready bus for mod_recombine: request and result channels.
interface mod_recombine_if
  import modcode_pkg::*;
#(
  parameter int unsigned M0LEN  = M0LEN_DEF,
  parameter int unsigned OUTLEN = 2 * M0LEN
) ();

  logic              in_valid;
  logic              in_ready;
  logic [M0LEN-1:0]  quotient;
  logic [M0LEN-1:0]  remainder;
  logic [M0LEN-1:0]  m0;
  logic              out_valid;
  logic              out_ready;
  logic [OUTLEN-1:0] dividend;
  logic              range_err;

  // Producer/consumer side.
  modport master (
    output in_valid, quotient, remainder, m0, out_ready,
    input  in_ready, out_valid, dividend, range_err
  );

  // Recombiner side.
  modport slave (
    input  in_valid, quotient, remainder, m0, out_ready,
    output in_ready, out_valid, dividend, range_err
  );

endinterface

// File: rtl/mod_recombine.sv
// Three-stage recombiner: dividend = quotient * m0 + remainder, with a flag
// for non-canonical inputs (remainder >= m0 or m0 == 0).
module mod_recombine
  import modcode_pkg::*;
#(
  parameter int unsigned M0LEN  = M0LEN_DEF,
  parameter int unsigned OUTLEN = 2 * M0LEN
) (
  input  logic            clk,
  input  logic            rst_n,
  mod_recombine_if.slave  bus
);

  localparam int unsigned PW = 2 * M0LEN;

  if (OUTLEN < 2 * M0LEN) begin : g_bad_outlen
    $error("mod_recombine: OUTLEN must be >= 2*M0LEN");
  end

  logic              en;

  logic              s1_vld_q;
  logic [M0LEN-1:0]  s1_quo_q;
  logic [M0LEN-1:0]  s1_rem_q;
  logic [M0LEN-1:0]  s1_m0_q;
  logic              s1_err_q;
  logic              s1_err_d;

  logic              s2_vld_q;
  logic [PW-1:0]     s2_prod_q;
  logic [M0LEN-1:0]  s2_rem_q;
  logic              s2_err_q;
  logic [PW-1:0]     s2_prod_d;

  logic              s3_vld_q;
  logic [OUTLEN-1:0] s3_div_q;
  logic              s3_err_q;
  logic [OUTLEN-1:0] s3_div_d;

  // Next-state datapath; the sum cannot overflow 2*M0LEN bits for any input.
  always_comb begin
    en        = !s3_vld_q || bus.out_ready;
    s1_err_d  = (bus.remainder >= bus.m0) || (bus.m0 == '0);
    s2_prod_d = PW'(s1_quo_q) * PW'(s1_m0_q);
    s3_div_d  = OUTLEN'(s2_prod_q) + OUTLEN'(s2_rem_q);
  end

  // Pipeline registers: valids advance on en; data loads only behind a valid
  // so the output holds its last result while out_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_quo_q  <= '0;
      s1_rem_q  <= '0;
      s1_m0_q   <= '0;
      s1_err_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_prod_q <= '0;
      s2_rem_q  <= '0;
      s2_err_q  <= 1'b0;
      s3_vld_q  <= 1'b0;
      s3_div_q  <= '0;
      s3_err_q  <= 1'b0;
    end else if (en) begin
      s1_vld_q <= bus.in_valid;
      s2_vld_q <= s1_vld_q;
      s3_vld_q <= s2_vld_q;
      if (bus.in_valid) begin
        s1_quo_q <= bus.quotient;
        s1_rem_q <= bus.remainder;
        s1_m0_q  <= bus.m0;
        s1_err_q <= s1_err_d;
      end
      if (s1_vld_q) begin
        s2_prod_q <= s2_prod_d;
        s2_rem_q  <= s1_rem_q;
        s2_err_q  <= s1_err_q;
      end
      if (s2_vld_q) begin
        s3_div_q <= s3_div_d;
        s3_err_q <= s2_err_q;
      end
    end
  end

  // Output drive: in_ready is the stall enable, independent of in_valid.
  always_comb begin
    bus.in_ready  = en;
    bus.out_valid = s3_vld_q;
    bus.dividend  = s3_div_q;
    bus.range_err = s3_err_q;
  end

endmodule
